// File: rtl/tim_capture_arb.sv
// Timestamp timer arbiter: grants one client, captures the timer, reads 4 bytes.
// Define TSARB_FIXED_PRIO_EN for fixed priority (req[0] highest) instead of round-robin.
module tim_capture_arb #(
    parameter int NREQ = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] ack,
    output logic [31:0]     timestamp,
    output logic [2:0]      gnt_id,
    output logic            busy,
    output logic            tim_cs_n,
    output logic            tim_rd_n,
    output logic            tim_wr_n,
    output logic [2:0]      tim_addr,
    output logic [7:0]      tim_wdata,
    input  logic [7:0]      tim_rdata
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] CAP  = 3'd1;
    localparam logic [2:0] RD0  = 3'd2;
    localparam logic [2:0] RD1  = 3'd3;
    localparam logic [2:0] RD2  = 3'd4;
    localparam logic [2:0] RD3  = 3'd5;
    localparam logic [2:0] DONE = 3'd6;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [2:0] winner;
    logic       any_req;

    assign any_req = |req;

`ifdef TSARB_FIXED_PRIO_EN
    // Lowest set index wins.
    always_comb begin
        winner = 3'd0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) winner = 3'(i);
        end
    end
`else
    logic [2:0]        rr_ptr;
    logic [2*NREQ-1:0] req2;

    assign req2 = {req, req};

    // First set request strictly after rr_ptr, wrapping through the doubled vector.
    always_comb begin
        winner = rr_ptr;
        for (int j = 2 * NREQ - 1; j >= 0; j--) begin
            if (req2[j] && (j > int'(rr_ptr)) && (j <= int'(rr_ptr) + NREQ))
                winner = 3'(j % NREQ);
        end
    end

    // Round-robin pointer follows each grant; starts so that req[0] goes first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            rr_ptr <= 3'(NREQ - 1);
        else if (state == IDLE && any_req)
            rr_ptr <= winner;
    end
`endif

    // Fixed capture/read sequence; requests are only looked at in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = CAP;
            CAP:     state_nxt = RD0;
            RD0:     state_nxt = RD1;
            RD1:     state_nxt = RD2;
            RD2:     state_nxt = RD3;
            RD3:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Latch the served client when leaving IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            gnt_id <= 3'd0;
        else if (state == IDLE && any_req)
            gnt_id <= winner;
    end

    // Assemble the captured count one byte per read state, LSB first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timestamp <= 32'd0;
        end else begin
            case (state)
                RD0:     timestamp[7:0]   <= tim_rdata;
                RD1:     timestamp[15:8]  <= tim_rdata;
                RD2:     timestamp[23:16] <= tim_rdata;
                RD3:     timestamp[31:24] <= tim_rdata;
                default: timestamp <= timestamp;
            endcase
        end
    end

    // Bus strobes decoded from registered state only.
    always_comb begin
        tim_cs_n = 1'b1;
        tim_rd_n = 1'b1;
        tim_wr_n = 1'b1;
        tim_addr = 3'd0;
        case (state)
            CAP: begin
                tim_cs_n = 1'b0;
                tim_wr_n = 1'b0;
                tim_addr = 3'd4;
            end
            RD0, RD1, RD2, RD3: begin
                tim_cs_n = 1'b0;
                tim_rd_n = 1'b0;
                tim_addr = state - RD0;
            end
            default: begin
                tim_cs_n = 1'b1;
            end
        endcase
    end

    // One-hot acknowledge to the served client in DONE.
    always_comb begin
        ack = '0;
        for (int i = 0; i < NREQ; i++) begin
            ack[i] = (state == DONE) && (gnt_id == 3'(i));
        end
    end

    assign busy      = (state != IDLE);
    assign tim_wdata = 8'h00;

endmodule

// File: doc/tim_capture_arb.md
# tim_capture_arb

Hardware-side sequencer and arbiter for the shared free-running timestamp timer peripheral. It accepts timestamp requests from up to NREQ hardware clients and grants one at a time. For the winner it drives the timer's processor-style bus: one capture write, then four byte reads. It assembles the 32-bit captured count and returns it with a one-cycle acknowledge. It sits between the client blocks and the timer, in place of the processor's bus connection.

## Interface
- NREQ, 4: number of requesters, 2..8.
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  level request per client; held high until that client's ack.
- ack  out  NREQ  one-cycle pulse to the served client; at most one bit set.
- timestamp  out  32  captured count; valid in the ack cycle, held until the next ack.
- gnt_id  out  3  index of the client currently or last served.
- busy  out  1  high in every state except IDLE.
- tim_cs_n  out  1  timer chip select, active-low.
- tim_rd_n  out  1  timer read strobe, active-low.
- tim_wr_n  out  1  timer write strobe, active-low.
- tim_addr  out  3  timer register address: 0..3 select count bytes 0..3 (LSB first); 4 is capture.
- tim_wdata  out  8  timer write data; always 8'h00 (the capture write ignores data).
- tim_rdata  in  8  timer read data; valid combinationally while cs_n=0, rd_n=0, wr_n=1.

## Operation
- FSM states: IDLE, CAP, RD0, RD1, RD2, RD3, DONE.
- IDLE
  - Strobes are inactive (cs_n=rd_n=wr_n=1) and tim_addr=0.
  - If any req bit is high, register the winner into gnt_id and go to CAP.
- CAP: cs_n=0, wr_n=0, rd_n=1, tim_addr=4. The timer latches its count on this cycle's closing edge. Next state is RD0.
- RDk (k=0..3)
  - Strobes are cs_n=0, rd_n=0, wr_n=1, tim_addr=k.
  - On the closing edge, tim_rdata is registered into timestamp byte k.
  - RD0→RD1→RD2→RD3→DONE.
- DONE
  - Strobes are inactive and ack[gnt_id]=1 for exactly this cycle. timestamp is complete.
  - Next state is always IDLE; there is no direct DONE→CAP path.
- Arbitration, default build: round-robin. Search starts at gnt_id+1 modulo NREQ and the first set req bit wins. After reset the pointer is NREQ-1, so req[0] has first priority.
- req is sampled only in IDLE. Changes to req during CAP..DONE do not affect the transaction in progress.
- If a client drops req mid-transaction, the transaction still completes and its ack still pulses.
- If a client still has req high in the IDLE cycle after its ack, that is a new request and enters arbitration normally.
- Only timestamp bytes being written change; the register otherwise holds its value.
- The strobes rd_n=0 and wr_n=0 are never asserted together. tim_cs_n=0 only in CAP and RD0..RD3.

## Timing
- Reset values: state IDLE, ack=0, timestamp=0, gnt_id=0, busy=0, tim_cs_n=1, tim_rd_n=1, tim_wr_n=1, tim_addr=0, tim_wdata=0.
- Reset is asynchronous. Asserting it mid-transaction forces all strobes inactive immediately and discards the partial timestamp. No ack is issued.
- Strobes and ack decode from registered state only, with no combinational path from req.
- Latency, with req high in IDLE cycle T:
  - CAP at T+1.
  - RD0..RD3 at T+2..T+5.
  - ack and valid timestamp at T+6.
  - IDLE again at T+7.
- Service period is 7 cycles per request. Sustained throughput is one timestamp per 7 cycles.
- The returned value is the timer count present during the CAP cycle.

## Configuration
- TSARB_FIXED_PRIO_EN
  - Defined: fixed priority, lowest index wins (req[0] highest). The round-robin pointer logic is not built. gnt_id still reports the served client.
  - Undefined: round-robin arbitration as described under Operation.

## Test plan
- Single request, timer model count=32'h0000_0100 in the CAP cycle: req[2] high → CAP, then RD0..RD3 with addr 0,1,2,3. ack=4'b0100 and timestamp=32'h0000_0100 at T+6.
- Byte order: timer holds 32'hA1B2_C3D4 → reads return D4, C3, B2, A1 → timestamp=32'hA1B2_C3D4.
- Round-robin with req=4'b1111 held continuously → acks served in order 0,1,2,3,0, each 7 cycles apart. With TSARB_FIXED_PRIO_EN defined and the same stimulus, client 0 is served every 7 cycles and the others starve.
- Mid-transaction change: req[1] served; req[0] asserted during RD1 and req[1] dropped during RD2 → ack[1] still pulses at DONE, then client 0 is granted at the next IDLE.
- Reset during RD2 → strobes go to 1 asynchronously and ack is never set. After release: timestamp=0, gnt_id=0, busy=0, and the next request proceeds normally.
- Protocol checker over all runs: never rd_n=0 && wr_n=0; cs_n=0 only in CAP..RD3; popcount(ack)≤1; ack is never high on consecutive cycles.
